// File: rtl/fc_pkg.sv
// Shared types and helpers for the tiled fully-connected layer: FSM state encoding,
// tile arithmetic and the round/saturate/ReLU result formatter.
package fc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StOut,
        StFinish
    } fc_state_e;

    localparam int unsigned DEF_OUT_LEN = 32;
    localparam int unsigned DEF_PE      = 8;
    localparam int unsigned TILES       = DEF_OUT_LEN / DEF_PE;

    function automatic int unsigned tile_count(input int unsigned out_len, input int unsigned pe);
        return out_len / pe;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Evaluated in 64 bits so the rounding add cannot wrap for any legal accumulator width.
    function automatic logic signed [63:0] fmt_result(
        input logic signed [63:0] acc,
        input int unsigned        frac,
        input int unsigned        dw,
        input bit                 relu
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (frac == 0) begin
            r = acc;
        end else begin
            r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_pe_mac.sv
// One neuron lane: signed multiply-accumulate plus a registered, formatted result word.
module fc_pe_mac
    import fc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_acc_en,
    input  logic                  i_capture,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_w,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        w_x_ext;
    logic signed [PW-1:0]        w_w_ext;
    logic signed [PW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [DATA_WIDTH-1:0] r_result;

    assign w_x_ext    = PW'($signed(i_x));
    assign w_w_ext    = PW'($signed(i_w));
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_acc_next = r_acc + ACC_WIDTH'(w_prod);

    // The result is formatted from the post-update sum so it is ready the cycle after the
    // last weight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= w_acc_next;
            end
            if (i_capture) begin
                r_result <= DATA_WIDTH'(fmt_result(64'(w_acc_next), FRAC_BITS, DATA_WIDTH,
                                                   RELU_EN != 0));
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/fc_layer_tiled.sv
// Tiled fixed-point fully-connected layer: buffers one input vector, then streams weight
// columns through PE parallel MAC lanes, emitting one result tile per OUT handshake.
module fc_layer_tiled
    import fc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IN_LEN     = 64,
    parameter int unsigned OUT_LEN    = 32,
    parameter int unsigned PE         = 8,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned RELU_EN    = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_FC,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              input_fc,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic [PE*DATA_WIDTH-1:0]           weightCaches_fc,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PE*DATA_WIDTH-1:0]           output_fc,
    output logic [idx_width(OUT_LEN/PE)-1:0]   out_tile,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned N_TILES = tile_count(OUT_LEN, PE);
    localparam int unsigned K_W     = idx_width(IN_LEN);
    localparam int unsigned T_W     = idx_width(N_TILES);

    fc_state_e             r_state;
    logic [K_W-1:0]        r_k;
    logic [T_W-1:0]        r_tile;
    logic [DATA_WIDTH-1:0] r_buf [IN_LEN];

    logic                  w_last_k;
    logic                  w_last_tile;
    logic                  w_in_hs;
    logic                  w_w_hs;
    logic                  w_out_hs;
    logic                  w_clear;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_x;

    assign w_last_k    = (r_k == K_W'(IN_LEN - 1));
    assign w_last_tile = (r_tile == T_W'(N_TILES - 1));
    assign w_in_hs     = (r_state == StLoad) && in_valid;
    assign w_w_hs      = (r_state == StCompute) && w_valid;
    assign w_out_hs    = (r_state == StOut) && out_ready;
    assign w_clear     = ((r_state == StIdle) && start_FC) || w_out_hs;
    assign w_capture   = w_w_hs && w_last_k;
    assign w_x         = r_buf[r_k];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_k     <= '0;
            r_tile  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start_FC) begin
                        r_k     <= '0;
                        r_tile  <= '0;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    if (w_in_hs) begin
                        if (w_last_k) begin
                            r_k     <= '0;
                            r_state <= StCompute;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    if (w_w_hs) begin
                        if (w_last_k) begin
                            r_k     <= '0;
                            r_state <= StOut;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (w_out_hs) begin
                        r_k <= '0;
                        if (w_last_tile) begin
                            r_state <= StFinish;
                        end else begin
                            r_tile  <= r_tile + 1'b1;
                            r_state <= StCompute;
                        end
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Buffer is deliberately left out of reset; every start reloads it in full.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_buf[r_k] <= input_fc;
        end
    end

    for (genvar j = 0; j < PE; j++) begin : g_lane
        fc_pe_mac #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ACC_WIDTH  (ACC_WIDTH),
            .RELU_EN    (RELU_EN)
        ) u_mac (
            .clk       (clk),
            .reset     (reset),
            .i_clear   (w_clear),
            .i_acc_en  (w_w_hs),
            .i_capture (w_capture),
            .i_x       (w_x),
            .i_w       (weightCaches_fc[j*DATA_WIDTH +: DATA_WIDTH]),
            .o_result  (output_fc[j*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign in_ready  = (r_state == StLoad);
    assign w_ready   = (r_state == StCompute);
    assign out_valid = (r_state == StOut);
    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StFinish);
    assign out_tile  = r_tile;

endmodule

// File: doc/fc_layer_tiled.md
# fc_layer_tiled

Fixed-point, parametrised successor to the fully-connected layer. It buffers one input vector of `IN_LEN` words, then computes `OUT_LEN` neurons in tiles of `PE` parallel MACs, streaming one weight column per cycle. Handshaking on the input, weight and output streams lets the surrounding CNN controller stall any side. Each tile emits one result word per neuron, rounded and saturated, with optional ReLU. The block sits after the last pooling stage and feeds the classifier/argmax stage.

## Interface
- `DATA_WIDTH`, 16: signed Q-format word width for inputs, weights and outputs.
- `FRAC_BITS`, 8: number of fractional bits.
- `IN_LEN`, 64: input vector length.
- `OUT_LEN`, 32: neuron count. Must be a multiple of `PE`.
- `PE`, 8: parallel MACs, i.e. neurons per tile.
- `ACC_WIDTH`, 40: accumulator width. Must be ≥ 2·`DATA_WIDTH` + clog2(`IN_LEN`).
- `RELU_EN`, 1: when 1, negative results are clamped to 0.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start_FC` in 1: one-cycle start pulse. Honoured only in IDLE.
- `in_valid` in 1, `in_ready` out 1, `input_fc` in `DATA_WIDTH`: input-vector stream.
- `w_valid` in 1, `w_ready` out 1, `weightCaches_fc` in `PE*DATA_WIDTH`: weight beat. Lane j is the weight for neuron tile·`PE`+j at input index k.
- `out_valid` out 1, `out_ready` in 1, `output_fc` out `PE*DATA_WIDTH`: tile result. Lane j is neuron tile·`PE`+j.
- `out_tile` out clog2(`OUT_LEN/PE`) (min 1): index of the presented tile.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last tile is accepted.

## Operation
- **States:** IDLE → LOAD → COMPUTE → OUT → (COMPUTE | FINISH) → IDLE.
- **IDLE:** on `start_FC`, clear the input index, tile counter and all accumulators, then go to LOAD.
- **LOAD:** `in_ready`=1. Each `in_valid`&&`in_ready` handshake writes `input_fc` to buffer[k] and increments k. After beat `IN_LEN`−1, reset k to 0 and go to COMPUTE.
- **COMPUTE:** `w_ready`=1. Each weight handshake does acc_j += buffer[k]·w_j (full-precision signed product, sign-extended into `ACC_WIDTH`). After beat `IN_LEN`−1, go to OUT.
- **OUT result per lane:**
  - r = (acc_j + 2^(`FRAC_BITS`−1)) >>> `FRAC_BITS` (arithmetic shift, round half up).
  - Saturate r to [−2^(`DATA_WIDTH`−1), 2^(`DATA_WIDTH`−1)−1].
  - Apply ReLU if `RELU_EN`.
  - Register the result into `output_fc`.
- **OUT hold:** `out_valid`=1, and `output_fc`/`out_tile` stay stable until `out_ready`.
- **On the OUT handshake:** clear the accumulators and set k=0. If this is not the last tile, increment the tile counter and go to COMPUTE; otherwise go to FINISH.
- **FINISH:** `done`=1 for one cycle, then IDLE. The input buffer is retained but is reloaded on every start.
- **`start_FC` while busy:** ignored, no side effects.
- **Reset** (any state, including mid-LOAD or mid-COMPUTE): go to IDLE and clear the counters, accumulators and `output_fc`. Partial results are discarded.

## Timing
- **Reset values:** `in_ready`=0, `w_ready`=0, `out_valid`=0, `output_fc`=0, `out_tile`=0, `busy`=0, `done`=0.
- **LOAD entry:** `in_ready` rises the cycle after `start_FC` is sampled.
- **Throughput:** one input word or one weight beat per cycle. Gaps in `in_valid`/`w_valid` only stall.
- **Tile latency:** `out_valid` rises the cycle after the last weight handshake of a tile.
- **Next tile:** `w_ready` rises the cycle after the OUT handshake.
- **Stall-free total:** 1 + `IN_LEN` + (`OUT_LEN`/`PE`)·(`IN_LEN`+1) cycles to the last `out_valid`, then `done` 1 cycle after that handshake.
- **Exclusivity:** `w_ready` and `out_valid` are never high together.
- **Backpressure:** `out_ready` low freezes everything.

## Structure
- **Package `fc_pkg`:**
  - state enum.
  - `TILES` = `OUT_LEN`/`PE`.
  - round/saturate/ReLU function, parameterised by the widths.
- **Sub-module `fc_pe_mac`:** one instance per lane, generated `PE` times. It holds the accumulator, the clear/accumulate enables and the result-formatting logic.
- **Top:** owns the FSM, the input buffer (`IN_LEN`×`DATA_WIDTH` registers) and the counters.

## Test plan
- **Basic:** defaults, inputs all 0x0100 (1.0), weights all 0x0080 (0.5) → 4 tiles, each lane 0x2000 (32.0), `out_tile` 0..3, `done` once.
- **Saturation:** weights 0x0400 → all lanes 0x7FFF. Weights 0xFC00 → 0x0000 with `RELU_EN`=1, 0x8000 with `RELU_EN`=0.
- **Rounding:** only input[0]=0x0001, rest 0. Weight 0x0080 → 0x0001. Weight 0x007F → 0x0000.
- **Backpressure:** hold `out_ready`=0 for 10 cycles on tile 1, plus random `in_valid`/`w_valid` gaps → `output_fc` stable, `w_ready`=0, results identical to the basic case.
- **Reset mid-COMPUTE:** assert `reset` after 20 beats of tile 2 → next cycle all outputs are at reset values. A fresh basic run then produces exact basic-case results.
- **Start while busy:** `start_FC` pulses during LOAD and OUT → ignored, results and cycle count unchanged.
